mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width in bits (legal 8..64, even).
REQ-002 SHALL have parameter MUL_CYCLES, default 5, meaning multiply latency in busy cycles (legal 1..31).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, meaning divide latency in busy cycles (legal 1..31).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  qualifies mdu_op for one cycle.
REQ-007 SHALL have port mdu_op  input  3  operation code per package encoding.
REQ-008 SHALL have port op_a  input  WIDTH  rs operand (dividend, multiplicand, or mthi/mtlo data).
REQ-009 SHALL have port op_b  input  WIDTH  rt operand (divisor, multiplier).
REQ-010 SHALL have port busy  output  1  operation in flight; issue stage stalls mult/div/mf/mt while high.
REQ-011 SHALL have port hi  output  WIDTH  architectural HI register.
REQ-012 SHALL have port lo  output  WIDTH  architectural LO register.

Function
REQ-013 SHALL use mdu_op encoding: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
REQ-014 SHALL implement FSM states IDLE, MUL, DIV; only IDLE accepts start.
REQ-015 SHALL, on start with MULT/MULTU in IDLE at edge k, latch the 2*WIDTH product, enter MUL, hold busy high edges k+1..k+MUL_CYCLES, write {hi,lo}=product at edge k+MUL_CYCLES, return to IDLE.
REQ-016 SHALL, on start with DIV/DIVU in IDLE at edge k, behave as REQ-015 with DIV_CYCLES, writing lo=quotient, hi=remainder.
REQ-017 SHALL truncate signed quotient toward zero; signed remainder takes dividend sign.
REQ-018 SHALL on divide-by-zero write lo=all-ones, hi=op_a, with full DIV_CYCLES latency.
REQ-019 SHALL on signed overflow (op_a=most-negative, op_b=-1) write lo=op_a, hi=0.
REQ-020 SHALL on MTHI/MTLO start in IDLE update hi/lo at the same edge, busy stays low.
REQ-021 SHALL ignore start (any op) while busy; HI/LO and in-flight operation unaffected.
REQ-022 SHALL treat NOP, and start low, as no action.
REQ-023 SHALL keep hi/lo stable (previous values) throughout busy; no partial result visible.
REQ-024 SHALL use an internal down-counter of width ceil(log2(max latency+1)); no wrap beyond 0.

Reset
REQ-025 SHALL on reset high at a rising edge set state=IDLE, counter=0, busy=0, hi=0, lo=0.
REQ-026 SHALL abort an in-flight operation on mid-operation reset; no result is committed.
REQ-027 SHALL give reset priority over start in the same cycle.

Configuration
REQ-028 SHALL, with macro MDU_MADD_EN defined, execute op 7 as signed multiply-accumulate: {hi,lo} += op_a*op_b (signed, modulo 2^(2*WIDTH)), MUL_CYCLES latency, accumulate base is {hi,lo} sampled at start.
REQ-029 SHALL, without MDU_MADD_EN, treat op 7 as NOP with no multiplier-adder logic synthesized.

Structure
REQ-030 SHALL place op encoding constants and FSM state encoding in shared package mdu_pkg.
REQ-031 SHALL be one flat module; no sub-module (result computed combinationally at start, latched, released by counter).

Verification (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10)
REQ-032 SHALL cover MULT op_a=0xFFFFFFFE (-2), op_b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 SHALL cover DIV op_a=-7, op_b=2 -> busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV op_a=0x80000000, op_b=-1 -> lo=0x80000000, hi=0.
REQ-034 SHALL cover DIVU op_a=100, op_b=0 -> after 10 cycles lo=0xFFFFFFFF, hi=100.
REQ-035 SHALL cover MULT start then MTHI 0x1234 on busy cycle 2 -> MTHI ignored, final hi equals product high word.
REQ-036 SHALL cover DIV start then reset at busy cycle 4 -> busy=0, hi=lo=0 next cycle, no later update.
REQ-037 SHALL cover (MDU_MADD_EN) MTLO 10, MTHI 0, then MADD op_a=3, op_b=4 -> after 5 cycles hi=0, lo=22; without macro -> hi=0, lo=10, busy never asserted.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e : operation codes carried on the mdu_op port
//   state_e  : sequencing FSM state encoding
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MADD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The full result is computed combinationally when an operation is accepted,
// parked in a result register, and released into HI/LO when the latency
// counter expires, so HI/LO never show a partial result.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous active-high reset
//   start          qualifies mdu_op for one cycle (accepted only when idle)
//   mdu_op[2:0]    operation code (mdu_pkg::mdu_op_e)
//   op_a, op_b     rs / rt operands
//   busy           operation in flight
//   hi, lo         architectural HI / LO registers
//
// Build option: define MDU_MADD_EN to execute op 7 as signed
// multiply-accumulate into {hi,lo}; otherwise op 7 is a NOP.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Signed product, sign-extended to full width before multiplying.
    function automatic logic [2*WIDTH-1:0] mul_signed(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ea;
        logic signed [2*WIDTH-1:0] eb;
        ea = {{WIDTH{a[WIDTH-1]}}, a};
        eb = {{WIDTH{b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_unsigned(input logic [WIDTH-1:0] a,
                                                         input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = {{WIDTH{1'b0}}, a};
        eb = {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Divide-by-zero and the single signed
    // overflow case are resolved explicitly rather than left to the operator.
    function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] q;
        logic signed [WIDTH-1:0] r;
        if (b == '0) begin
            return {a, {WIDTH{1'b1}}};
        end else if (a == MOST_NEG && b == {WIDTH{1'b1}}) begin
            return {{WIDTH{1'b0}}, a};
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
    endfunction

    function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] a,
                                                         input logic [WIDTH-1:0] b);
        if (b == '0) begin
            return {a, {WIDTH{1'b1}}};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]   res_q,   res_d;
    logic [WIDTH-1:0]     hi_q,    hi_d;
    logic [WIDTH-1:0]     lo_q,    lo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT: begin
                            res_d   = mul_signed(op_a, op_b);
                            cnt_d   = MUL_LOAD;
                            state_d = ST_MUL;
                        end
                        OP_MULTU: begin
                            res_d   = mul_unsigned(op_a, op_b);
                            cnt_d   = MUL_LOAD;
                            state_d = ST_MUL;
                        end
                        OP_DIV: begin
                            res_d   = div_signed(op_a, op_b);
                            cnt_d   = DIV_LOAD;
                            state_d = ST_DIV;
                        end
                        OP_DIVU: begin
                            res_d   = div_unsigned(op_a, op_b);
                            cnt_d   = DIV_LOAD;
                            state_d = ST_DIV;
                        end
                        OP_MTHI: hi_d = op_a;
                        OP_MTLO: lo_d = op_a;
`ifdef MDU_MADD_EN
                        // Accumulate base is HI/LO as seen at acceptance;
                        // they cannot change while the operation is busy.
                        OP_MADD: begin
                            res_d   = {hi_q, lo_q} + mul_signed(op_a, op_b);
                            cnt_d   = MUL_LOAD;
                            state_d = ST_MUL;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                // Commit on the last busy cycle; never decrement past zero.
                if (cnt_q <= CNT_ONE) begin
                    {hi_d, lo_d} = res_q;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Result holding register is pure data; it is only observed after a load.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Present one start pulse; it is sampled on the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 3'd0;
    endtask

    // Count busy cycles (bounded) and note whether HI/LO moved while busy.
    task automatic wait_done(output int n, output bit stable);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        n = 0;
        stable = 1'b1;
        while (busy && n < 100) begin
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        // Reset wins over a simultaneous MTHI.
        @(negedge clk);
        start = 1'b1; mdu_op = 3'd5; op_a = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0; mdu_op = 3'd0;
        checks++;
        if (hi !== 32'h0) begin
            errors++;
            $display("FAIL reset_priority: hi=%h, want 00000000", hi);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int n; bit st; logic [63:0] exp;
        sb.push_back(64'hFFFFFFFF_FFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_done(n, st);
        exp = sb.pop_front();
        checks++;
        if (n !== 5 || !st) begin
            errors++;
            $display("FAIL mult_latency: busy=%0d stable=%0d, want 5/1", n, st);
        end
        checks++;
        if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL mult_result: got %h, want %h", {hi, lo}, exp);
        end
        sb.push_back(64'h00000002_FFFFFFFA);
        issue(3'd2, 32'hFFFFFFFE, 32'd3);
        wait_done(n, st);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || n !== 5) begin
            errors++;
            $display("FAIL multu_result: got %h busy=%0d, want %h busy=5", {hi, lo}, n, exp);
        end
    endtask

    task automatic test_div;
        int n; bit st; logic [63:0] exp;
        logic [2:0]  ops[4] = '{3'd3, 3'd3, 3'd4, 3'd3};
        logic [31:0] as[4]  = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFFFB};
        logic [31:0] bs[4]  = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [63:0] ex[4]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000,
                                64'h00000064_FFFFFFFF, 64'hFFFFFFFB_FFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ex[i]);
            issue(ops[i], as[i], bs[i]);
            wait_done(n, st);
            exp = sb.pop_front();
            checks++;
            if (n !== 10 || !st) begin
                errors++;
                $display("FAIL div_latency[%0d]: busy=%0d stable=%0d, want 10/1", i, n, st);
            end
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL div_result[%0d]: got %h, want %h", i, {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_random;
        int n; bit st; logic [63:0] exp;
        logic [31:0] a, b;
        longint unsigned ua, ub;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 5) ? 32'd7 : $urandom_range(1, 32'hFFFF);
            ua = {32'h0, a};
            ub = {32'h0, b};
            if (i % 2 == 0) begin
                sb.push_back(ua * ub);
                issue(3'd2, a, b);
            end else begin
                sb.push_back({32'(ua % ub), 32'(ua / ub)});
                issue(3'd4, a, b);
            end
            wait_done(n, st);
            exp = sb.pop_front();
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h got %h, want %h", i, a, b, {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_mt_nop;
        issue(3'd6, 32'h0000AAAA, 32'h0);
        checks++;
        if (lo !== 32'h0000AAAA || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: lo=%h busy=%b, want 0000aaaa/0", lo, busy);
        end
        issue(3'd5, 32'h0000BBBB, 32'h0);
        checks++;
        if (hi !== 32'h0000BBBB || lo !== 32'h0000AAAA || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b, want 0000bbbb/0000aaaa/0", hi, lo, busy);
        end
        issue(3'd0, 32'h1, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h0000BBBB || lo !== 32'h0000AAAA || busy !== 1'b0) begin
            errors++;
            $display("FAIL nop: hi=%h lo=%h busy=%b, want unchanged/0", hi, lo, busy);
        end
    endtask

    task automatic test_ignore_while_busy;
        int n; bit st; logic [63:0] exp;
        sb.push_back(64'hFFFFFFFF_FFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        issue(3'd5, 32'h00001234, 32'h0);
        wait_done(n, st);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || n !== 4 || !st) begin
            errors++;
            $display("FAIL ignore_busy: got %h rem_busy=%0d stable=%0d, want %h/4/1",
                     {hi, lo}, n, st, exp);
        end
    endtask

    task automatic test_reset_midop;
        bit clean;
        issue(3'd5, 32'h55, 32'h0);
        issue(3'd6, 32'h66, 32'h0);
        issue(3'd3, 32'd1000, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        reset = 1'b0;
        clean = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) clean = 1'b0;
        end
        checks++;
        if (!clean) begin
            errors++;
            $display("FAIL reset_no_commit: hi=%h lo=%h busy=%b, want quiet zeros", hi, lo, busy);
        end
    endtask

    task automatic test_madd;
        int n; bit st; logic [63:0] exp;
        issue(3'd6, 32'd10, 32'h0);
        issue(3'd5, 32'd0, 32'h0);
`ifdef MDU_MADD_EN
        sb.push_back(64'h00000000_00000016);
        issue(3'd7, 32'd3, 32'd4);
        wait_done(n, st);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || n !== 5 || !st) begin
            errors++;
            $display("FAIL madd: got %h busy=%0d stable=%0d, want %h/5/1", {hi, lo}, n, st, exp);
        end
`else
        sb.push_back(64'h00000000_0000000A);
        issue(3'd7, 32'd3, 32'd4);
        st = 1'b1;
        n = 0;
        repeat (7) begin
            if (busy !== 1'b0) st = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || !st) begin
            errors++;
            $display("FAIL madd_disabled: got %h busy_seen=%0d, want %h never busy", {hi, lo}, !st, exp);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int n1, n2; bit s1, s2; logic [63:0] e1, e2;
        sb.push_back(64'h00000000_0000002A);
        sb.push_back(64'h00000001_00000006);
        issue(3'd2, 32'd6, 32'd7);
        wait_done(n1, s1);
        e1 = sb.pop_front();
        checks++;
        if ({hi, lo} !== e1 || n1 !== 5) begin
            errors++;
            $display("FAIL b2b_first: got %h busy=%0d, want %h/5", {hi, lo}, n1, e1);
        end
        issue(3'd4, 32'd43, 32'd7);
        wait_done(n2, s2);
        e2 = sb.pop_front();
        checks++;
        if ({hi, lo} !== e2 || n2 !== 10 || !s2) begin
            errors++;
            $display("FAIL b2b_second: got %h busy=%0d, want %h/10", {hi, lo}, n2, e2);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_mt_nop();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_midop();
        test_madd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
